// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared 8-bit system bus.
// Optional macro BUS_ARB_LOCK_EN adds M0_LOCK/M1_LOCK for locked back-to-back re-grants.
module bus_arbiter #(
  parameter logic [7:0] IDLE_ADDR = 8'hFF,
  parameter int         READ_WAIT = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  inout  wire  [7:0] BUS_DATA,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  input  logic       M0_REQ,
  input  logic [7:0] M0_ADDR,
  input  logic       M0_WE,
  input  logic [7:0] M0_WDATA,
  output logic       M0_GNT,
  output logic       M0_ACK,
  output logic [7:0] M0_RDATA,
`ifdef BUS_ARB_LOCK_EN
  input  logic       M0_LOCK,
  input  logic       M1_LOCK,
`endif
  input  logic       M1_REQ,
  input  logic [7:0] M1_ADDR,
  input  logic       M1_WE,
  input  logic [7:0] M1_WDATA,
  output logic       M1_GNT,
  output logic       M1_ACK,
  output logic [7:0] M1_RDATA
);

  localparam logic [2:0] READ_WAIT_CNT = 3'(READ_WAIT);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACK} state_t;

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       last_grant_reg, last_grant_next;
  logic [7:0] addr_reg, addr_next;
  logic       we_reg, we_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] bus_addr_reg, bus_addr_next;
  logic       bus_we_reg, bus_we_next;
  logic       drive_reg, drive_next;
  logic [1:0] gnt_reg, gnt_next;
  logic [1:0] ack_reg, ack_next;
  logic [1:0] capture;
  logic [7:0] rdata_reg [2];

  logic [1:0] req, we_in, lock, cand;
  logic [7:0] addr_in [2];
  logic [7:0] wdata_in [2];
  logic       win_valid, win, locked;

  assign req         = {M1_REQ, M0_REQ};
  assign we_in       = {M1_WE, M0_WE};
  assign addr_in[0]  = M0_ADDR;
  assign addr_in[1]  = M1_ADDR;
  assign wdata_in[0] = M0_WDATA;
  assign wdata_in[1] = M1_WDATA;

`ifdef BUS_ARB_LOCK_EN
  assign lock = {M1_LOCK, M0_LOCK};
`else
  assign lock = 2'b00;
`endif

  // In ACK the owner's own REQ is stale, so it only counts when locked.
  always_comb begin
    cand = req;
    if (state_reg == ACK) cand[owner_reg] = 1'b0;
    locked    = (state_reg == ACK) && lock[owner_reg] && req[owner_reg];
    win_valid = locked || (|cand);
    if (locked)        win = owner_reg;
    else if (&cand)    win = ~last_grant_reg;
    else               win = cand[1];
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    we_next         = we_reg;
    wdata_next      = wdata_reg;
    cnt_next        = cnt_reg;
    bus_addr_next   = IDLE_ADDR;
    bus_we_next     = 1'b0;
    drive_next      = 1'b0;
    gnt_next        = gnt_reg;
    ack_next        = 2'b00;
    capture         = 2'b00;

    case (state_reg)
      IDLE, ACK: begin
        if (win_valid) begin
          state_next    = ADDR;
          owner_next    = win;
          addr_next     = addr_in[win];
          we_next       = we_in[win];
          wdata_next    = wdata_in[win];
          gnt_next      = win ? 2'b10 : 2'b01;
          bus_addr_next = addr_in[win];
          bus_we_next   = we_in[win];
          drive_next    = we_in[win];
          if (!locked) last_grant_next = win;
        end else begin
          state_next = IDLE;
          gnt_next   = 2'b00;
        end
      end
      ADDR: begin
        if (we_reg) begin
          state_next          = ACK;
          ack_next[owner_reg] = 1'b1;
        end else begin
          state_next = WAIT;
          cnt_next   = READ_WAIT_CNT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) begin
          cnt_next            = 3'd0;
          capture[owner_reg]  = 1'b1;
          ack_next[owner_reg] = 1'b1;
          state_next          = ACK;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      bus_addr_reg   <= IDLE_ADDR;
      bus_we_reg     <= 1'b0;
      drive_reg      <= 1'b0;
      gnt_reg        <= 2'b00;
      ack_reg        <= 2'b00;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      cnt_reg        <= cnt_next;
      bus_addr_reg   <= bus_addr_next;
      bus_we_reg     <= bus_we_next;
      drive_reg      <= drive_next;
      gnt_reg        <= gnt_next;
      ack_reg        <= ack_next;
    end
  end

  // Read data is held per master until that master's next read completes.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdata
      always_ff @(posedge CLK) begin
        if (!RESET_N)         rdata_reg[gi] <= '0;
        else if (capture[gi]) rdata_reg[gi] <= BUS_DATA;
      end
    end
  endgenerate

  assign BUS_DATA = drive_reg ? wdata_reg : 8'hzz;
  assign BUS_ADDR = bus_addr_reg;
  assign BUS_WE   = bus_we_reg;
  assign M0_GNT   = gnt_reg[0];
  assign M1_GNT   = gnt_reg[1];
  assign M0_ACK   = ack_reg[0];
  assign M1_ACK   = ack_reg[1];
  assign M0_RDATA = rdata_reg[0];
  assign M1_RDATA = rdata_reg[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter with a registered-read RAM at 0x00-0x7F.
// Define BUS_ARB_LOCK_EN to also exercise the locked re-grant sequence.
module tb_bus_arbiter;
  localparam int READ_WAIT = 1;

  typedef struct { bit m; bit chk; logic [7:0] rdata; int cyc; } ack_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  [7:0] bus_data;
  logic [7:0] bus_addr;
  logic bus_we;
  logic m0_req = 1'b0, m0_we = 1'b0, m0_gnt, m0_ack;
  logic m1_req = 1'b0, m1_we = 1'b0, m1_gnt, m1_ack;
  logic [7:0] m0_addr = '0, m0_wdata = '0, m0_rdata;
  logic [7:0] m1_addr = '0, m1_wdata = '0, m1_rdata;
`ifdef BUS_ARB_LOCK_EN
  logic m0_lock = 1'b0, m1_lock = 1'b0;
`endif

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ack_t ack_q[$];
  wr_t  wr_q[$];

  bus_arbiter #(.IDLE_ADDR(8'hFF), .READ_WAIT(READ_WAIT)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .BUS_DATA(bus_data), .BUS_ADDR(bus_addr), .BUS_WE(bus_we),
    .M0_REQ(m0_req), .M0_ADDR(m0_addr), .M0_WE(m0_we), .M0_WDATA(m0_wdata),
    .M0_GNT(m0_gnt), .M0_ACK(m0_ack), .M0_RDATA(m0_rdata),
`ifdef BUS_ARB_LOCK_EN
    .M0_LOCK(m0_lock), .M1_LOCK(m1_lock),
`endif
    .M1_REQ(m1_req), .M1_ADDR(m1_addr), .M1_WE(m1_we), .M1_WDATA(m1_wdata),
    .M1_GNT(m1_gnt), .M1_ACK(m1_ack), .M1_RDATA(m1_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: registered read, drives the bus the cycle after a read address.
  logic [7:0] mem [0:127];
  logic ram_oe = 1'b0;
  logic [7:0] ram_q = '0;
  assign bus_data = ram_oe ? ram_q : 8'hzz;
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  always @(posedge clk) begin
    ram_oe <= (bus_addr < 8'h80) && !bus_we;
    ram_q  <= mem[bus_addr[6:0]];
    if (bus_we && bus_addr < 8'h80) mem[bus_addr[6:0]] <= bus_data;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: pop expectations as ACKs and bus writes appear.
  always @(negedge clk) begin
    ack_t e;
    wr_t  w;
    if (rst_n) begin
      check("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'd0);
      if (m0_ack || m1_ack) begin
        if (ack_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
        else begin
          e = ack_q.pop_front();
          $display("ack m%0d cycle %0d rdata %0h", m1_ack, cyc, m1_ack ? m1_rdata : m0_rdata);
          check("ack_master", 32'(m1_ack), 32'(e.m));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.chk) check("rdata", 32'(e.m ? m1_rdata : m0_rdata), 32'(e.rdata));
        end
      end
      if (bus_we) begin
        if (wr_q.size() == 0) check("bus_we_unexpected", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(bus_addr), 32'(w.addr));
          check("wr_data", 32'(bus_data), 32'(w.data));
          check("wr_cycle", 32'(cyc), 32'(w.cyc));
        end
      end
    end
  end

  // Hold REQ until ACK, then drop it in the following cycle.
  task automatic bus_req(input bit m, input bit we, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    if (!m) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
    do begin @(negedge clk); n++; end while (!(m ? m1_ack : m0_ack) && n < 40);
    if (!(m ? m1_ack : m0_ack)) check(m ? "m1_timeout" : "m0_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (!m) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  // Single transfer issued while the arbiter is idle.
  task automatic solo(input bit m, input bit we, input logic [7:0] a, input logic [7:0] d,
                      input bit chk, input logic [7:0] exp);
    ack_t e;
    wr_t  w;
    e.m = m; e.chk = !we && chk; e.rdata = exp;
    e.cyc = cyc + (we ? 2 : 2 + READ_WAIT);
    ack_q.push_back(e);
    if (we) begin w.addr = a; w.data = d; w.cyc = cyc + 1; wr_q.push_back(w); end
    bus_req(m, we, a, d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    ack_t e;
    wr_t  w;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_addr", 32'(bus_addr), 32'hFF);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    check("rst_ack", 32'({m1_ack, m0_ack}), 32'd0);
    check("rst_rdata", 32'({m1_rdata, m0_rdata}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    solo(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00);
    solo(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5);
    solo(1'b0, 1'b0, 8'h90, 8'h00, 1'b0, 8'h00);
    solo(1'b0, 1'b1, 8'h11, 8'h5A, 1'b0, 8'h00);
    solo(1'b0, 1'b1, 8'h12, 8'h3C, 1'b0, 8'h00);
    solo(1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 8'h5A);
    solo(1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 8'h3C);

    // Reset during an M1 read wait state aborts without an ACK.
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wait_gnt", 32'(m1_gnt), 32'd1);
    check("wait_bus_addr", 32'(bus_addr), 32'hFF);
    rst_n = 1'b0;
    @(posedge clk); #1 m1_req = 1'b0;
    @(negedge clk);
    check("abort_bus_addr", 32'(bus_addr), 32'hFF);
    check("abort_bus_we", 32'(bus_we), 32'd0);
    check("abort_ack", 32'(m1_ack), 32'd0);
    check("abort_gnt", 32'(m1_gnt), 32'd0);
    check("abort_rdata", 32'(m1_rdata), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Both masters request continuously: strict alternation, no idle cycles.
    do_reset();
    base = cyc;
    for (int i = 0; i < 6; i++) begin
      e.m = i[0]; e.chk = 1'b0; e.rdata = '0; e.cyc = base + 2 + 2 * i;
      ack_q.push_back(e);
      w.addr = 8'(8'h20 + i); w.data = 8'(8'hC0 + i); w.cyc = base + 1 + 2 * i;
      wr_q.push_back(w);
    end
    fork
      begin
        for (int k = 0; k < 3; k++) bus_req(1'b0, 1'b1, 8'(8'h20 + 2 * k), 8'(8'hC0 + 2 * k));
      end
      begin
        for (int j = 0; j < 3; j++) bus_req(1'b1, 1'b1, 8'(8'h21 + 2 * j), 8'(8'hC1 + 2 * j));
      end
    join
    for (int r = 0; r < 6; r++)
      solo(~r[0], 1'b0, 8'(8'h20 + r), 8'h00, 1'b1, 8'(8'hC0 + r));

`ifdef BUS_ARB_LOCK_EN
    // M0 keeps LOCK+REQ for three writes while M1 waits its turn.
    do_reset();
    base = cyc;
    for (int i = 0; i < 4; i++) begin
      e.m = (i == 3); e.chk = 1'b0; e.rdata = '0; e.cyc = base + 2 + 2 * i;
      ack_q.push_back(e);
      w.addr = (i == 3) ? 8'h50 : 8'(8'h40 + i);
      w.data = (i == 3) ? 8'h80 : 8'(8'h70 + i);
      w.cyc  = base + 1 + 2 * i;
      wr_q.push_back(w);
    end
    m0_lock = 1'b1; m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h40; m0_wdata = 8'h70;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h50; m1_wdata = 8'h80;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!m0_ack && n < 40);
      if (!m0_ack) check("lock_m0_timeout", 32'd1, 32'd0);
      if (k < 2) begin m0_addr = 8'(8'h41 + k); m0_wdata = 8'(8'h71 + k); end
      else begin m0_req = 1'b0; m0_lock = 1'b0; end
    end
    bus_req(1'b1, 1'b1, 8'h50, 8'h80);
`endif

    repeat (4) @(posedge clk);
    check("ack_q_empty", 32'(ack_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared 8-bit system bus (BUS_DATA / BUS_ADDR / BUS_WE) that the RAM and memory-mapped peripherals sit on.
- Accepts single-byte read/write requests from two masters (M0: microprocessor, M1: DMA/debug engine).
- Grants the bus round-robin, drives address, write-enable and write data, waits the fixed slave read latency, captures read data and returns it with a one-cycle ACK.
- It is the only block that drives BUS_ADDR and BUS_WE.

Parameters:
- IDLE_ADDR, 8'hFF: address driven when no transfer is active; must decode to no slave so nothing drives BUS_DATA.
- READ_WAIT, 1: cycles between the address cycle and the read-data sample; legal range 1..7; 1 matches RAM registered read.

Ports:
- CLK  in  1  system clock, all logic on posedge
- RESET_N  in  1  synchronous active-low reset
- BUS_DATA  inout  8  shared data bus; driven only during write address cycle, else 8'hZZ
- BUS_ADDR  out  8  bus address
- BUS_WE  out  1  bus write enable
- M0_REQ  in  1  M0 request, held until M0_ACK
- M0_ADDR  in  8  M0 address, stable while M0_REQ high
- M0_WE  in  1  M0 1=write 0=read
- M0_WDATA  in  8  M0 write data
- M0_GNT  out  1  M0 owns bus
- M0_ACK  out  1  one-cycle transfer-complete pulse
- M0_RDATA  out  8  read data, valid when M0_ACK high, held until next M0 read ACK
- M1_REQ, M1_ADDR, M1_WE, M1_WDATA, M1_GNT, M1_ACK, M1_RDATA: identical to M0 for master 1

Behaviour:
- All outputs registered except the BUS_DATA tristate.
- States: IDLE, ADDR, WAIT, ACK.
- Reset values: state IDLE; BUS_ADDR=IDLE_ADDR; BUS_WE=0; BUS_DATA=Z; GNT/ACK=0; RDATA=0; last_grant=1 (M0 wins first); wait counter=0.
- Reset mid-transfer: abort immediately, bus released, no ACK issued for the aborted transfer.
- Arbitration (in IDLE and ACK):
  - Only one REQ: that master wins.
  - Both REQ: master != last_grant wins.
  - In ACK, the REQ of the master being acked is ignored.
  - Winner: latch its ADDR/WE/WDATA, set its GNT, update last_grant, go to ADDR next cycle.
  - No winner: go to IDLE.
- ADDR (1 cycle):
  - BUS_ADDR = latched address; BUS_WE = latched WE.
  - Write: BUS_DATA = latched WDATA; go to ACK.
  - Read: BUS_DATA = Z; load counter = READ_WAIT; go to WAIT.
- WAIT:
  - BUS_ADDR = IDLE_ADDR, BUS_WE = 0; decrement counter.
  - When counter reaches 1, sample BUS_DATA into the owner's RDATA and go to ACK.
- ACK (1 cycle):
  - Owner ACK=1, GNT stays 1; bus idle (IDLE_ADDR, WE=0, Z).
  - Arbitrate as above for the next cycle.
- Latency from REQ seen in IDLE:
  - Write: ACK 2 cycles later (bus write occurs at end of ADDR).
  - Read: ACK READ_WAIT+2 cycles later.
- Back-to-back:
  - Other master pending in ACK: its ADDR cycle follows immediately (no idle cycle).
  - Same master re-requesting: passes through IDLE, so the other master can win if it requests meanwhile.
- Bus contention rule: a write ADDR never follows a cycle where the bus address was a readable slave with WE=0. Guaranteed because WAIT and ACK drive IDLE_ADDR.
- Read of an undecoded address: sampled value is whatever BUS_DATA resolves to; the transfer still completes normally (no timeout).
- GNT is one-hot or zero, never both high.
- Latched address/data are unaffected by master input changes after the arbitration cycle.

Optional Feature:
- Macro: BUS_ARB_LOCK_EN.
- When defined:
  - Adds ports M0_LOCK and M1_LOCK (in, 1).
  - In ACK, if the owner has LOCK=1 and REQ=1, the owner is re-granted directly into ADDR next cycle, overriding round-robin.
  - last_grant is unchanged by a locked re-grant.
  - LOCK is ignored in IDLE.
- When undefined: ports absent; strict round-robin as above.

Test Plan:
- Reset, then M0 write addr 8'h10 data 8'hA5 → BUS_ADDR=10, BUS_WE=1, BUS_DATA=A5 for exactly one cycle; M0_ACK 2 cycles after REQ; RAM[0x10]=A5.
- M1 read addr 8'h10 after that write, READ_WAIT=1 → M1_ACK 3 cycles after REQ; M1_RDATA=A5; BUS_DATA Z in the ACK cycle.
- M0 and M1 both request every cycle from reset → grants alternate M0, M1, M0, M1; no IDLE cycles between transfers; GNT never both 1.
- RESET_N low during M1 read WAIT → next cycle: IDLE, BUS_ADDR=FF, BUS_WE=0, no M1_ACK; RDATA=0.
- Read of 8'h90 (outside RAM, no slave) → ACK still issued at the nominal cycle; no BUS_DATA drive by the arbiter.
- With BUS_ARB_LOCK_EN: M0 holds LOCK+REQ for 3 writes while M1 requests → M0 gets 3 consecutive transfers, then M1 is granted in the next arbitration.
